// File: rtl/regfile_sb.sv
// regfile_sb: parametrised LEGv8 register file.
//   - two combinational read ports, one synchronous write port
//   - hardwired zero register (ZERO_REG) that always reads 0
//   - reset-driven init sequencer: register i <- i
//   - per-register pending bits for multi-cycle producers
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read bypass).

// One read port: zero/out-of-range squash, optional bypass select.
module regfile_sb_rport #(
    parameter int N        = 64,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = NREGS - 1,
    parameter int AW       = 5
) (
    input  logic                      ready,
    input  logic [4:0]                ra,
    input  logic [NREGS-1:0][N-1:0]   mem,
    input  logic [NREGS-1:0]          pend,
    input  logic                      hit,
    input  logic [N-1:0]              wd,
    input  logic                      hit_busy,
    output logic [N-1:0]              rd,
    output logic                      busy
);
    logic ok;
    assign ok = (int'(ra) < NREGS) && (int'(ra) != ZERO_REG);

    // Stored value unless the in-flight write targets this address.
    always_comb begin
        rd   = '0;
        busy = 1'b0;
        if (ready && ok) begin
            if (hit) begin
                rd   = wd;
                busy = hit_busy;
            end else begin
                rd   = mem[ra[AW-1:0]];
                busy = pend[ra[AW-1:0]];
            end
        end
    end
endmodule

module regfile_sb #(
    parameter int N        = 64,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = NREGS - 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         we3,
    input  logic [4:0]   wa3,
    input  logic [N-1:0] wd3,
    input  logic [4:0]   ra1,
    input  logic [4:0]   ra2,
    output logic [N-1:0] rd1,
    output logic [N-1:0] rd2,
    input  logic         pend_set,
    input  logic [4:0]   pend_wa,
    output logic         busy1,
    output logic         busy2,
    output logic         ready
);
    localparam int AW = $clog2(NREGS);
    localparam logic [0:0] S_INIT  = 1'b0;
    localparam logic [0:0] S_READY = 1'b1;

    logic [0:0]               state;
    logic [AW-1:0]            cnt;
    logic [NREGS-1:0][N-1:0]  mem;
    logic [NREGS-1:0]         pend;
    logic                     wr_ok, ps_ok;

    // Writable address: in range and not the zero register.
    function automatic logic addr_ok(input logic [4:0] a);
        return (int'(a) < NREGS) && (int'(a) != ZERO_REG);
    endfunction

    assign ready = (state == S_READY);
    assign wr_ok = ready && we3 && addr_ok(wa3);
    assign ps_ok = ready && pend_set && addr_ok(pend_wa);

    // Data array: init sequencer writes index values, then the external port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == S_INIT) begin
                if (int'(cnt) != ZERO_REG)
                    mem[cnt] <= N'(cnt);
            end else if (wr_ok) begin
                mem[wa3[AW-1:0]] <= wd3;
            end
        end
    end

    // Init FSM and scoreboard; a same-cycle pend_set overrides the write's clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_INIT;
            cnt   <= '0;
            pend  <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == AW'(NREGS - 2))
                        state <= S_READY;
                end
                default: begin
                    if (wr_ok) pend[wa3[AW-1:0]]     <= 1'b0;
                    if (ps_ok) pend[pend_wa[AW-1:0]] <= 1'b1;
                end
            endcase
        end
    end

    logic [1:0][4:0]   ra;
    logic [1:0][N-1:0] rd;
    logic [1:0]        busy, hit, hit_busy;

    assign ra    = {ra2, ra1};
    assign rd1   = rd[0];
    assign rd2   = rd[1];
    assign busy1 = busy[0];
    assign busy2 = busy[1];

    for (genvar p = 0; p < 2; p++) begin : gen_port
`ifdef REGFILE_BYPASS_EN
        // The in-flight write resolves the hazard unless a new producer is issued.
        assign hit[p]      = wr_ok && (wa3 == ra[p]);
        assign hit_busy[p] = pend_set && (pend_wa == ra[p]);
`else
        assign hit[p]      = 1'b0;
        assign hit_busy[p] = 1'b0;
`endif
        regfile_sb_rport #(
            .N(N), .NREGS(NREGS), .ZERO_REG(ZERO_REG), .AW(AW)
        ) u_rport (
            .ready   (ready),
            .ra      (ra[p]),
            .mem     (mem),
            .pend    (pend),
            .hit     (hit[p]),
            .wd      (wd3),
            .hit_busy(hit_busy[p]),
            .rd      (rd[p]),
            .busy    (busy[p])
        );
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard bench for regfile_sb (default 32x64 and a 16x32 instance).
module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        reset = 1'b0, we3 = 1'b0, pend_set = 1'b0;
    logic [4:0]  wa3 = '0, ra1 = '0, ra2 = '0, pend_wa = '0;
    logic [63:0] wd3 = '0;
    logic [63:0] rd1, rd2;
    logic        busy1, busy2, ready;
    logic [31:0] s_rd1, s_rd2;
    logic        s_busy1, s_busy2, s_ready;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .pend_set(pend_set), .pend_wa(pend_wa),
        .busy1(busy1), .busy2(busy2), .ready(ready)
    );

    regfile_sb #(.N(32), .NREGS(16)) dut_s (
        .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3[31:0]),
        .ra1(ra1), .ra2(ra2), .rd1(s_rd1), .rd2(s_rd2),
        .pend_set(pend_set), .pend_wa(pend_wa),
        .busy1(s_busy1), .busy2(s_busy2), .ready(s_ready)
    );

    // Reference model: index 0 = 32x64 instance, index 1 = 16x32 instance.
    int          nr[2]   = '{32, 16};
    logic [63:0] mask[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
    logic [63:0] mregs[2][32];
    bit          mpend[2][32];
    int          minit[2];
    bit          mready[2];
    bit          known = 1'b0;

    typedef struct {
        logic [1:0][63:0] rd1, rd2;
        logic [1:0]       b1, b2, rdy;
    } exp_t;
    exp_t q[$];

    int checks = 0, failures = 0;

    function automatic bit usable(int k, logic [4:0] a);
        return mready[k] && int'(a) < nr[k] && int'(a) != nr[k] - 1;
    endfunction

    function automatic bit bypass_hit(int k, logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
        return we3 && wa3 == a;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [63:0] m_rd(int k, logic [4:0] a);
        if (!usable(k, a)) return 64'd0;
        if (bypass_hit(k, a)) return wd3 & mask[k];
        return mregs[k][a];
    endfunction

    function automatic logic m_busy(int k, logic [4:0] a);
        if (!usable(k, a)) return 1'b0;
        if (bypass_hit(k, a)) return pend_set && pend_wa == a;
        return mpend[k][a];
    endfunction

    // Advance model state across one posedge, using the inputs held at that edge.
    function automatic void m_update(int k);
        if (reset) begin
            mready[k] = 1'b0;
            minit[k]  = 0;
            for (int i = 0; i < 32; i++) mpend[k][i] = 1'b0;
        end else if (!mready[k]) begin
            minit[k]++;
            if (minit[k] == nr[k] - 1) begin
                mready[k] = 1'b1;
                for (int i = 0; i < 32; i++) mregs[k][i] = 64'(i);
            end
        end else begin
            if (we3 && int'(wa3) < nr[k] - 1) begin
                mregs[k][wa3] = wd3 & mask[k];
                mpend[k][wa3] = 1'b0;
            end
            if (pend_set && int'(pend_wa) < nr[k] - 1)
                mpend[k][pend_wa] = 1'b1;
        end
    endfunction

    task automatic step(input bit r, input bit w, input logic [4:0] wa, input logic [63:0] wd,
                        input logic [4:0] a1, input logic [4:0] a2, input bit ps, input logic [4:0] pw);
        exp_t e;
        reset = r; we3 = w; wa3 = wa; wd3 = wd; ra1 = a1; ra2 = a2; pend_set = ps; pend_wa = pw;
        if (known) begin
            for (int k = 0; k < 2; k++) begin
                e.rdy[k] = mready[k];
                e.rd1[k] = m_rd(k, a1);
                e.rd2[k] = m_rd(k, a2);
                e.b1[k]  = m_busy(k, a1);
                e.b2[k]  = m_busy(k, a2);
            end
            q.push_back(e);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) m_update(k);
        if (reset) known = 1'b1;
        #1;
    endtask

    task automatic rstep();
        step(1'b0, 1'($urandom % 2), 5'($urandom_range(0, 31)), {$urandom, $urandom},
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             1'($urandom % 3 == 0), 5'($urandom_range(0, 31)));
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // Monitor: outputs are settled mid-cycle; pop and compare one entry per cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("ready",     64'(ready),    64'(e.rdy[0]));
            chk("rd1",       rd1,           e.rd1[0]);
            chk("rd2",       rd2,           e.rd2[0]);
            chk("busy1",     64'(busy1),    64'(e.b1[0]));
            chk("busy2",     64'(busy2),    64'(e.b2[0]));
            chk("s_ready",   64'(s_ready),  64'(e.rdy[1]));
            chk("s_rd1",     64'(s_rd1),    e.rd1[1]);
            chk("s_rd2",     64'(s_rd2),    e.rd2[1]);
            chk("s_busy1",   64'(s_busy1),  64'(e.b1[1]));
            chk("s_busy2",   64'(s_busy2),  64'(e.b2[1]));
        end
    end

    initial begin
        @(posedge clk); #1;
        // Reset two cycles, then init with garbage on the write/pending inputs.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 3, 64'h55, 3, 4, 1, 3);
        for (int i = 0; i < 31; i++) rstep();
        // Init values and zero/out-of-range reads.
        step(0, 0, 0, 0, 5, 30, 0, 0);
        step(0, 0, 0, 0, 31, 14, 0, 0);
        step(0, 0, 0, 0, 15, 20, 0, 0);
        // Zero register is never written and never pending.
        step(0, 1, 31, 64'hDEAD, 0, 0, 0, 0);
        step(0, 0, 0, 0, 31, 31, 1, 31);
        step(0, 0, 0, 0, 31, 15, 0, 0);
        // Same-cycle write/read, then next-cycle read.
        step(0, 1, 7, 64'h1234, 7, 7, 0, 0);
        step(0, 0, 0, 0, 7, 6, 0, 0);
        // Scoreboard on X9.
        step(0, 0, 0, 0, 9, 9, 1, 9);
        step(0, 1, 9, 64'hAB, 9, 9, 1, 9);
        step(0, 0, 0, 0, 0, 9, 0, 0);
        step(0, 1, 9, 64'hCD, 0, 9, 0, 0);
        step(0, 0, 0, 0, 9, 9, 0, 0);
        // Out-of-range write for the small instance.
        step(0, 1, 20, 64'hFEED_F00D_1234_5678, 20, 14, 0, 0);
        step(0, 0, 0, 0, 20, 14, 0, 0);
        // Reset mid-init, then re-init and sweep every register.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) rstep();
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 31; i++) rstep();
        for (int i = 0; i < 32; i++) step(0, 0, 0, 0, 5'(i), 5'(31 - i), 0, 0);
        // Random traffic; narrow address window to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            step(1'b0, 1'($urandom % 2), 5'($urandom_range(5, 12)), {$urandom, $urandom},
                 5'($urandom_range(5, 12)), 5'($urandom_range(0, 31)),
                 1'($urandom % 3 == 0), 5'($urandom_range(5, 12)));
        end
        @(negedge clk); #1;
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file for the LEGv8 datapath, replacing the fixed 32×64 file. It keeps two combinational read ports, one synchronous write port and a hardwired zero register (XZR). It adds:
- a reset-driven initialisation sequencer that loads register i with value i;
- a per-register pending (scoreboard) bit for multi-cycle producers such as loads;
- optional same-cycle write-to-read bypass.

It sits between decode and the ALU/forwarding logic.

## Interface
Parameters:
- N, 64: data width in bits.
- NREGS, 32: number of architectural registers, including XZR; legal range 2..32.
- ZERO_REG, NREGS-1: index of the hardwired zero register.

Ports:
- clk, input, 1: clock; all state updates on posedge.
- reset, input, 1: synchronous, active-high reset; one clock, reset is synchronous and active-high.
- we3, input, 1: write enable.
- wa3, input, 5: write address.
- wd3, input, N: write data.
- ra1, input, 5: read address, port 1.
- ra2, input, 5: read address, port 2.
- rd1, output, N: read data, port 1.
- rd2, output, N: read data, port 2.
- pend_set, input, 1: mark register pend_wa as pending.
- pend_wa, input, 5: register to mark pending.
- busy1, output, 1: register ra1 is pending.
- busy2, output, 1: register ra2 is pending.
- ready, output, 1: initialisation complete; file usable.

## Operation
State machine, two states: INIT and READY.

Reset:
- reset=1 at posedge → state INIT, init counter=0, all pending bits cleared.
- Reset applies from any state, including mid-INIT; the counter restarts at 0.

INIT:
- Each cycle writes register[cnt] = cnt, zero-extended to N bits, then increments cnt.
- When the cycle with cnt = NREGS-2 completes, the state moves to READY.
- External we3 and pend_set are ignored.
- ready=0, rd1=rd2=0, busy1=busy2=0.

READY:
- ready=1.
- Write: on posedge, if we3=1, wa3≠ZERO_REG and wa3<NREGS, then register[wa3] ← wd3 and pending[wa3] ← 0.
- Pending set: on posedge, if pend_set=1, pend_wa≠ZERO_REG and pend_wa<NREGS, then pending[pend_wa] ← 1.
- Write and pend_set to the same register in the same cycle: data is written and the pending bit ends at 1 (set wins; a new producer has been issued).
- Read: rdX = 0 if raX=ZERO_REG or raX≥NREGS; otherwise rdX = register[raX] (combinational).
- busyX = pending[raX]. It is 0 for ZERO_REG and for out-of-range addresses.
- The zero register is never written and never pending.

Width rules:
- Addresses are always 5 bits; bits beyond NREGS range are decoded as out-of-range.
- The init value i is zero-extended to N bits.

## Timing
- Reset values: ready=0, rd1=rd2=0, busy1=busy2=0, all pending bits=0.
- Register contents are undefined until INIT completes.
- INIT latency: ready rises at the posedge ending cycle NREGS-1 after reset deasserts. For NREGS=32 this is 31 cycles.
- Read latency: 0 cycles (combinational from raX and state).
- Write latency: 1 cycle. The new value is visible on rdX the cycle after the write posedge (without bypass).
- Pending visibility: a bit set at posedge k is visible on busyX from cycle k+1. A write at posedge k clears busyX from cycle k+1.
- Write and read of the same register in the same cycle: without bypass, rdX returns the old value.

## Configuration
Macro: REGFILE_BYPASS_EN.

When defined:
- In READY, if we3=1, wa3=raX, wa3≠ZERO_REG and wa3<NREGS, then rdX = wd3 in the same cycle.
- In that case busyX = pend_set && pend_wa==raX, i.e. the in-flight write is treated as resolving the hazard.

When undefined:
- rdX and busyX reflect only stored state.
- A same-cycle write is not visible to reads.

## Test plan
- Init sequence: assert reset 2 cycles, then release; count cycles → ready=0 for exactly 31 cycles, then ready=1; reading X5 gives 5 and X30 gives 30; X31 gives 0.
- Reset mid-INIT: reset at cycle 10 of INIT → ready stays 0 for a further 31 cycles after release; all registers then hold their index.
- Zero register: we3=1, wa3=31, wd3=64'hDEAD → next cycle rd1 for ra1=31 is 0. pend_set with pend_wa=31 → busy1=0.
- Write/read: write X7 ← 64'h1234; read X7 in the same cycle → 7 without the macro, 64'h1234 with REGFILE_BYPASS_EN. Next cycle → 64'h1234 in both builds.
- Scoreboard: pend_set X9 → busy2=1 next cycle for ra2=9. Write X9 plus pend_set X9 in the same cycle → busy2 stays 1. A later write to X9 alone → busy2=0 next cycle.
- Parametrisation: NREGS=16, N=32 → ready after 15 cycles; ra1=15 reads 0; ra1=20 reads 0; a write to wa3=20 is ignored; X14 reads 14.
